cmd_pulse_exec: RTL

Command executor directly downstream of the command-register/scheduler stage. It latches the command presented with a DATA_WR strobe and waits until system TIME reaches TIME_START. It then plays out a blanking/pulse-train sequence with per-pulse or intra-pulse frequency stepping. When the sequence completes, it raises REQ_COMM so the upstream stage erases the executed command and delivers the next one.

---
 rtl/cmd_pulse_exec_if.sv | 35 +++
 rtl/cmd_pulse_exec.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_pulse_exec_if.sv
// Command/timing bus between the upstream command scheduler and cmd_pulse_exec.
// The scheduler side (master) drives TIME and the command fields. The executor side (slave) drives the gates and status.
interface cmd_pulse_exec_if #(parameter int CW = 32);
  logic [63:0]   TIME;
  logic          DATA_WR;
  logic [47:0]   FREQ_z;
  logic [47:0]   FREQ_STEP_z;
  logic [CW-1:0] FREQ_RATE_z;
  logic [63:0]   TIME_START_z;
  logic [15:0]   N_impuls_z;
  logic [1:0]    TYPE_impulse_z;
  logic [CW-1:0] Interval_Ti_z;
  logic [CW-1:0] Interval_Tp_z;
  logic [CW-1:0] Tblank1_z;
  logic [CW-1:0] Tblank2_z;
  logic          IMPULSE;
  logic          BLANK;
  logic [47:0]   FREQ_OUT;
  logic          FREQ_STB;
  logic          REQ_COMM;
  logic          BUSY;
  logic [31:0]   TEST;

  modport master (
    output TIME, DATA_WR, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, TIME_START_z, N_impuls_z,
           TYPE_impulse_z, Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z,
    input  IMPULSE, BLANK, FREQ_OUT, FREQ_STB, REQ_COMM, BUSY, TEST
  );

  modport slave (
    input  TIME, DATA_WR, FREQ_z, FREQ_STEP_z, FREQ_RATE_z, TIME_START_z, N_impuls_z,
           TYPE_impulse_z, Interval_Ti_z, Interval_Tp_z, Tblank1_z, Tblank2_z,
    output IMPULSE, BLANK, FREQ_OUT, FREQ_STB, REQ_COMM, BUSY, TEST
  );
endinterface

// File: rtl/cmd_pulse_exec.sv
// Timed command executor: arms on DATA_WR, waits for TIME >= TIME_START, then plays blank1 / pulse train / blank2.
// Afterwards it holds REQ_COMM for REQ_HOLD cycles. DATA_WR is a one-cycle strobe with the fields valid in that cycle.
module cmd_pulse_exec #(
  parameter int REQ_HOLD = 4,
  parameter int CW       = 32
) (
  input logic            CLK,
  input logic            rst,
  cmd_pulse_exec_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_BLANK1, S_PULSE, S_GAP, S_BLANK2, S_DONE
  } state_t;

  typedef struct packed {
    logic [47:0]   freq;
    logic [47:0]   step;
    logic [CW-1:0] rate;
    logic [63:0]   tstart;
    logic [15:0]   n;
    logic [1:0]    ptype;
    logic [CW-1:0] ti;
    logic [CW-1:0] tp;
    logic [CW-1:0] tb1;
    logic [CW-1:0] tb2;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          shadow_q, shadow_d, pend_q, pend_d, wr_cmd;
  logic          pend_valid_q, pend_valid_d;
  logic          late_q, late_d;
  logic          first_cmp_q, first_cmp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [15:0]   pcnt_q, pcnt_d;
  logic [47:0]   freq_q, freq_d;
  logic          stb_q, stb_d;

  logic          time_hit, cnt_last, done_last;
  logic [CW-1:0] pulse_w, gap_w;
  state_t        after_blank2, train_entry, after_arm;
  logic [1:0]    st_code;

  assign wr_cmd = {bus.FREQ_z, bus.FREQ_STEP_z, bus.FREQ_RATE_z, bus.TIME_START_z, bus.N_impuls_z,
                   bus.TYPE_impulse_z, bus.Interval_Ti_z, bus.Interval_Tp_z, bus.Tblank1_z, bus.Tblank2_z};

  assign time_hit  = (bus.TIME >= shadow_q.tstart);
  assign cnt_last  = (cnt_q == '0);
  assign done_last = (state_q == S_DONE) && cnt_last;
  assign pulse_w   = (shadow_q.ti == '0) ? CW'(1) : shadow_q.ti;
  // Tp <= Ti still spends one low cycle so consecutive pulses keep a visible edge.
  assign gap_w     = (shadow_q.tp > shadow_q.ti) ? (shadow_q.tp - shadow_q.ti) : CW'(1);

  // Zero-length phases are skipped by chaining the successor choice.
  assign after_blank2 = (shadow_q.tb2 != '0) ? S_BLANK2 : S_DONE;
  assign train_entry  = (shadow_q.n != '0) ? S_PULSE : after_blank2;
  assign after_arm    = (shadow_q.tb1 != '0) ? S_BLANK1 : train_entry;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    late_d       = late_q;
    first_cmp_d  = first_cmp_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    pcnt_d       = pcnt_q;
    freq_d       = freq_q;
    stb_d        = 1'b0;

    case (state_q)
      S_IDLE:   if (bus.DATA_WR) state_d = S_ARMED;
      S_ARMED: begin
        if (time_hit && !bus.DATA_WR) state_d = after_arm;
        if (first_cmp_q) begin
          first_cmp_d = 1'b0;
          if (time_hit) late_d = 1'b1;
        end
      end
      S_BLANK1: if (cnt_last) state_d = train_entry;
      S_PULSE:  if (cnt_last) state_d = S_GAP;
      S_GAP:    if (cnt_last) state_d = (pcnt_q == '0) ? after_blank2 : S_PULSE;
      S_BLANK2: if (cnt_last) state_d = S_DONE;
      S_DONE:   if (cnt_last) state_d = (bus.DATA_WR || pend_valid_q) ? S_ARMED : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // A write while running is parked; it is promoted when the REQ_COMM window closes.
    if (bus.DATA_WR) begin
      late_d = 1'b0;
      if (state_q == S_IDLE || state_q == S_ARMED || done_last) begin
        shadow_d     = wr_cmd;
        first_cmp_d  = 1'b1;
        pend_valid_d = 1'b0;
      end else begin
        pend_d       = wr_cmd;
        pend_valid_d = 1'b1;
      end
    end else if (done_last && pend_valid_q) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
      first_cmp_d  = 1'b1;
    end

    if (state_d != state_q) begin
      rcnt_d = '0;
      case (state_d)
        S_BLANK1: cnt_d = shadow_q.tb1 - CW'(1);
        S_PULSE: begin
          cnt_d = pulse_w - CW'(1);
          if (state_q != S_GAP) begin
            pcnt_d = shadow_q.n;
            freq_d = shadow_q.freq;
            stb_d  = 1'b1;
          end else if (shadow_q.ptype == 2'd1) begin
            freq_d = shadow_q.freq;
            stb_d  = (freq_q != shadow_q.freq);
          end else if (shadow_q.ptype == 2'd2) begin
            freq_d = freq_q + shadow_q.step;
            stb_d  = 1'b1;
          end
        end
        S_GAP: begin
          cnt_d  = gap_w - CW'(1);
          pcnt_d = pcnt_q - 16'd1;
        end
        S_BLANK2: cnt_d = shadow_q.tb2 - CW'(1);
        S_DONE:   cnt_d = CW'(REQ_HOLD - 1);
        default:  ;
      endcase
    end else if (state_q != S_IDLE && state_q != S_ARMED) begin
      cnt_d = cnt_q - CW'(1);
      // Chirp steps land only on cycles that stay inside the pulse.
      if (state_q == S_PULSE && shadow_q.ptype == 2'd1 && shadow_q.rate != '0) begin
        if (rcnt_q == shadow_q.rate - CW'(1)) begin
          rcnt_d = '0;
          freq_d = freq_q + shadow_q.step;
          stb_d  = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shadow_q     <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      late_q       <= 1'b0;
      first_cmp_q  <= 1'b0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      pcnt_q       <= '0;
      freq_q       <= '0;
      stb_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      late_q       <= late_d;
      first_cmp_q  <= first_cmp_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      pcnt_q       <= pcnt_d;
      freq_q       <= freq_d;
      stb_q        <= stb_d;
    end
  end

  always_comb begin
    st_code = 2'd2;
    case (state_q)
      S_IDLE:  st_code = 2'd0;
      S_ARMED: st_code = 2'd1;
      S_DONE:  st_code = 2'd3;
      default: st_code = 2'd2;
    endcase
  end

  assign bus.IMPULSE  = (state_q == S_PULSE);
  assign bus.BLANK    = (state_q == S_BLANK1) || (state_q == S_BLANK2);
  assign bus.REQ_COMM = (state_q == S_DONE);
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.FREQ_OUT = freq_q;
  assign bus.FREQ_STB = stb_q;
  assign bus.TEST     = {28'h0, late_q, pend_valid_q, st_code};

endmodule
